robot_collector_ctrl: RTL and testbench

ROBOT_COLLECTOR_CTRL -- requirements
Module: robot_collector_ctrl

---
 rtl/robot_collector_pkg.sv | 27 ++
 rtl/robot_timer.sv | 26 ++
 rtl/robot_collector_ctrl.sv | 148 ++++++++++++++
 tb/tb_robot_collector_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/robot_collector_pkg.sv
// Shared types for the wall-following trash collector: state encoding,
// output-decode constants {advance,turn,collect,fault} and a sizing helper.
package robot_collector_pkg;

  typedef enum logic [2:0] {
    STAND_BY    = 3'd0,
    SEARCH_WALL = 3'd1,
    FOLLOW_WALL = 3'd2,
    TURN_90     = 3'd3,
    COLLECT     = 3'd4,
    FAULT       = 3'd5
  } state_t;

  // Output word order: {advance, turn, collect, fault}
  localparam logic [3:0] OUT_IDLE    = 4'b0000;
  localparam logic [3:0] OUT_MOVE    = 4'b1000;
  localparam logic [3:0] OUT_TURN    = 4'b0100;
  localparam logic [3:0] OUT_COLLECT = 4'b0010;
  localparam logic [3:0] OUT_FAULT   = 4'b0001;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/robot_timer.sv
// Saturating down timer: load has priority, then count toward zero and hold.
// Ports: clock, reset (sync, active-high), load, load_value, expired (count==0).
module robot_timer #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/robot_collector_ctrl.sv
// Moore FSM for a wall-following trash-collecting robot.
// Ports: clock, reset (sync, active-high), head, left, barrier, under in;
// advance, turn, collect, fault out; with TRASH_COUNT_EN also trash_count
// and bin_full (saturating collection counter; a full bin ignores barrier).
module robot_collector_ctrl
  import robot_collector_pkg::*;
#(
  parameter int TURN_CYCLES  = 4,
  parameter int COLLECT_MAX  = 8,
  parameter int SEARCH_LIMIT = 16
`ifdef TRASH_COUNT_EN
  ,
  parameter int CNT_W        = 8
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic barrier,
  input  logic under,
  output logic advance,
  output logic turn,
  output logic collect,
  output logic fault
`ifdef TRASH_COUNT_EN
  ,
  output logic [CNT_W-1:0] trash_count,
  output logic             bin_full
`endif
);

  localparam int TW =
    $clog2(max3(TURN_CYCLES, COLLECT_MAX, SEARCH_LIMIT) + 1);

  // Timer holds N-1 on entry, so expiry is seen in the Nth cycle.
  localparam logic [TW-1:0] TURN_LD   = TW'(TURN_CYCLES - 1);
  localparam logic [TW-1:0] COLL_LD   = TW'(COLLECT_MAX - 1);
  localparam logic [TW-1:0] SEARCH_LD = TW'(SEARCH_LIMIT - 1);

  state_t        state, next;
  logic          load, reload, expired, full, brr;
  logic [TW-1:0] load_value;
  logic [3:0]    out;

  robot_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .expired    (expired)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= STAND_BY;
    else
      state <= next;
  end

  assign brr = barrier & ~full;

  always_comb begin
    next   = state;
    reload = 1'b0;
    unique case (state)
      STAND_BY:    next = SEARCH_WALL;
      SEARCH_WALL: begin
        if (brr)          next = COLLECT;
        else if (head)    next = TURN_90;
        else if (left)    next = FOLLOW_WALL;
        else if (expired) next = TURN_90;
      end
      FOLLOW_WALL: begin
        if (brr)        next = COLLECT;
        else if (head)  next = TURN_90;
        else if (!left) next = SEARCH_WALL;
      end
      TURN_90: begin
        if (brr) next = COLLECT;
        else if (expired) begin
          if (head)      reload = 1'b1;
          else if (left) next = FOLLOW_WALL;
          else           next = SEARCH_WALL;
        end
      end
      COLLECT: begin
        if (!brr)
          next = left ? FOLLOW_WALL : SEARCH_WALL;
        else if (expired)
          next = FAULT;
      end
      FAULT:   next = FAULT;
      default: next = STAND_BY;
    endcase
    if (under && state != FAULT)
      next = STAND_BY;
  end

  always_comb begin
    load_value = '0;
    unique case (next)
      SEARCH_WALL: load_value = SEARCH_LD;
      TURN_90:     load_value = TURN_LD;
      COLLECT:     load_value = COLL_LD;
      default:     load_value = '0;
    endcase
    load = (next != state) | reload;
  end

  always_comb begin
    out = OUT_IDLE;
    unique case (state)
      SEARCH_WALL,
      FOLLOW_WALL: out = OUT_MOVE;
      TURN_90:     out = OUT_TURN;
      COLLECT:     out = OUT_COLLECT;
      FAULT:       out = OUT_FAULT;
      default:     out = OUT_IDLE;
    endcase
  end

  assign {advance, turn, collect, fault} = out;

`ifdef TRASH_COUNT_EN
  logic [CNT_W-1:0] count;
  logic             done;

  // A completed collection leaves COLLECT toward a wall state;
  // timeouts and standby requests do not count.
  assign done = (state == COLLECT) &&
                (next == SEARCH_WALL || next == FOLLOW_WALL);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (done && !full)
      count <= count + 1'b1;
  end

  assign full        = &count;
  assign trash_count = count;
  assign bin_full    = full;
`else
  assign full = 1'b0;
`endif

endmodule

// File: tb/tb_robot_collector_ctrl.sv
// Table-driven bench for robot_collector_ctrl with an expected-output queue.
// Output word checked each cycle is {advance,turn,collect,fault}.
module tb_robot_collector_ctrl;

  logic clock = 1'b0;
  logic reset, head, left, barrier, under;
  logic advance, turn, collect, fault;
`ifdef TRASH_COUNT_EN
  logic [1:0] trash_count;
  logic       bin_full;
`endif

  always #5 clock = ~clock;

  robot_collector_ctrl #(
    .TURN_CYCLES  (4),
    .COLLECT_MAX  (8),
    .SEARCH_LIMIT (16)
`ifdef TRASH_COUNT_EN
    ,
    .CNT_W        (2)
`endif
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .head    (head),
    .left    (left),
    .barrier (barrier),
    .under   (under),
    .advance (advance),
    .turn    (turn),
    .collect (collect),
    .fault   (fault)
`ifdef TRASH_COUNT_EN
    ,
    .trash_count (trash_count),
    .bin_full    (bin_full)
`endif
  );

  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] A = 4'b1000;
  localparam logic [3:0] T = 4'b0100;
  localparam logic [3:0] C = 4'b0010;
  localparam logic [3:0] F = 4'b0001;

  typedef struct {
    logic       rst, und, hd, lf, br;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  // in = {rst, under, head, left, barrier}
  task automatic add(input logic [4:0] in, input logic [3:0] e,
                     input int n, input string nm);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      {v.rst, v.und, v.hd, v.lf, v.br} = in;
      v.exp  = e;
      v.name = nm;
      tbl.push_back(v);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [3:0] e;
    reset   = v.rst;
    under   = v.und;
    head    = v.hd;
    left    = v.lf;
    barrier = v.br;
    exp_q.push_back(v.exp);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check(v.name, {28'd0, advance, turn, collect, fault}, {28'd0, e});
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; under = 1'b0; head = 1'b0;
    left = 1'b0; barrier = 1'b0;

    add(5'b10000, N, 2,  "reset");
    add(5'b00000, A, 16, "search_adv");
    add(5'b00000, T, 4,  "search_timeout_turn");
    add(5'b00000, A, 1,  "turn_to_search");
    add(5'b00110, T, 1,  "head_left_turn");
    add(5'b00010, T, 3,  "turn_hold");
    add(5'b00010, A, 3,  "follow_wall");
    add(5'b00011, C, 3,  "collect_3");
    add(5'b00010, A, 2,  "collect_done");
    add(5'b00011, C, 8,  "collect_max");
    add(5'b00011, F, 2,  "fault");
    add(5'b01000, F, 3,  "fault_under");
    add(5'b11000, N, 1,  "reset_fault");
    add(5'b00000, A, 1,  "release");
    add(5'b00100, T, 1,  "turn_start");
    add(5'b00000, T, 1,  "turn_mid");
    add(5'b01000, N, 1,  "under_mid_turn");
    add(5'b00000, A, 1,  "resume");
    add(5'b00001, C, 2,  "collect_mid");
    add(5'b10001, N, 1,  "reset_mid_collect");
    add(5'b01000, N, 2,  "under_hold");
    add(5'b00000, A, 1,  "resume2");
    add(5'b00100, T, 6,  "turn_reload");
    add(5'b00000, T, 2,  "turn_reload_tail");
    add(5'b00000, A, 1,  "turn_reload_end");
    add(5'b00100, T, 1,  "turn_again");
    add(5'b00001, C, 1,  "barrier_in_turn");
    add(5'b00000, A, 1,  "collect_to_search");
    add(5'b00101, C, 1,  "barrier_over_head");
    add(5'b00000, A, 1,  "collect_to_search2");

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

`ifdef TRASH_COUNT_EN
    v.name = "tc_reset";
    {v.rst, v.und, v.hd, v.lf, v.br} = 5'b10000; v.exp = N; apply(v);
    check("tc_cleared", {30'd0, trash_count}, 32'd0);
    check("bf_cleared", {31'd0, bin_full}, 32'd0);
    v.name = "tc_release";
    {v.rst, v.und, v.hd, v.lf, v.br} = 5'b00000; v.exp = A; apply(v);
    for (int i = 0; i < 3; i++) begin
      v.name = "tc_collect";
      {v.rst, v.und, v.hd, v.lf, v.br} = 5'b00001; v.exp = C; apply(v);
      v.name = "tc_exit";
      {v.rst, v.und, v.hd, v.lf, v.br} = 5'b00000; v.exp = A; apply(v);
      check("tc_count", {30'd0, trash_count}, i + 1);
      check("tc_full", {31'd0, bin_full}, (i == 2) ? 32'd1 : 32'd0);
    end
    v.name = "tc_full_ignores_barrier";
    {v.rst, v.und, v.hd, v.lf, v.br} = 5'b00001; v.exp = A; apply(v);
    apply(v);
    check("tc_saturated", {30'd0, trash_count}, 32'd3);
    v.name = "tc_reset2";
    {v.rst, v.und, v.hd, v.lf, v.br} = 5'b10001; v.exp = N; apply(v);
    check("tc_reset_clear", {30'd0, trash_count}, 32'd0);
    check("bf_reset_clear", {31'd0, bin_full}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
